// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder
//
// Purpose:
//   Registered N-to-log2(N) encoder with request memory.
//   - Single-cycle request pulses on iData are latched into a pending vector.
//   - Pending requests are issued one index at a time through a valid/ready output stage.
//   - A pending bit clears at the moment its index is loaded into oData.
//
// Configuration macro:
//   ROUND_ROBIN_EN
//     Defined:   round-robin search that starts just after the last issued index.
//     Undefined: fixed priority, where the highest set index wins.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   iData      in   N  request pulses; bit k requests index k
//   iReady     in   1  consumer accepts oData this cycle
//   oData      out  W  encoded index of the current grant (keeps its last value when idle)
//   oValid     out  1  oData is valid; held until accepted
//   oPending   out  N  registered pending vector (the bit held in oData is already cleared)
//   oOverflow  out  1  sticky flag: a request hit a bit that was still pending

module pending_priority_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] iData,
  input  logic         iReady,
  output logic [W-1:0] oData,
  output logic         oValid,
  output logic [N-1:0] oPending,
  output logic         oOverflow
);

  logic [N-1:0] pending;
  logic [N-1:0] clr;
  logic [W-1:0] sel;
  logic         load;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr;

  // Search starts at ptr+1 and wraps modulo N, so the index just issued is
  // tried last. ptr=N-1 therefore starts the search at index 0.
  always_comb begin
    logic         found;
    logic [W-1:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // The pointer remembers the last issued index and only moves on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= sel;
    end
  end
`else
  // Fixed priority: later iterations overwrite earlier ones, so the highest
  // set index wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        sel = W'(i);
      end
    end
  end
`endif

  // A new grant is loaded whenever the output stage is empty or is being
  // accepted this cycle. Selection reads only the registered pending vector,
  // so a request needs one edge to be captured before it can be issued.
  always_comb begin
    load = (!oValid || iReady) && (pending != '0);
    clr  = '0;
    if (load) begin
      clr[sel] = 1'b1;
    end
  end

  // Pending capture, sticky overflow and the output stage.
  // - OR-ing iData in after the clear makes a same-edge re-request win over
  //   the clear.
  // - A request that collides with a still-pending bit is absorbed, so no
  //   duplicate issue happens; only the overflow flag records it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      oData     <= '0;
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | iData;
      if ((iData & pending & ~clr) != '0) begin
        oOverflow <= 1'b1;
      end
      if (load) begin
        oData  <= sel;
        oValid <= 1'b1;
      end else if (iReady) begin
        oValid <= 1'b0;
      end
    end
  end

  assign oPending = pending;

endmodule
